// File: rtl/sram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port SRAM.
package sram_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_e;

   function automatic int byte_count(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/sram_init_ctrl.sv
// Memory-clear sequencer: walks every address once after reset, then parks in READY.
module sram_init_ctrl #(
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  init_busy,
   output logic                  init_we,
   output logic [ADDR_WIDTH-1:0] init_addr
);
   import sram_pkg::*;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      init_busy = 1'b0;
      init_we   = 1'b0;
      init_addr = cnt_q;
      case (state_q)
         INIT: begin
            init_busy = 1'b1;
            init_we   = 1'b1;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = READY;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sram_dp_be.sv
// Dual-port SRAM with byte enables, write-first bypass and 1/2-cycle read latency.
// Optional per-byte even parity when SRAM_PARITY_EN is defined.
module sram_dp_be #(
   parameter int ADDR_WIDTH   = 4,
   parameter int DATA_WIDTH   = 16,
   parameter int READ_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic                    rd_en,
   input  logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_valid,
   output logic                    init_busy,
   output logic                    par_err
);
   import sram_pkg::*;

   localparam int NB    = byte_count(DATA_WIDTH);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic                  init_we;
   logic [ADDR_WIDTH-1:0] init_addr;
   logic                  wr_fire, rd_fire, same_addr;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  rd_perr;

   sram_init_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_init (
      .clk       (clk),
      .rst_n     (rst_n),
      .init_busy (init_busy),
      .init_we   (init_we),
      .init_addr (init_addr)
   );

   assign wr_fire   = wr_en & ~init_busy;
   assign rd_fire   = rd_en & ~init_busy;
   assign same_addr = wr_fire && (wr_addr == rd_addr);

   // Storage deliberately has no reset; the clear sequence zeroes it.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (init_we) begin
         mem_q[init_addr] <= '0;
      end else if (wr_fire) begin
         for (int b = 0; b < NB; b++)
            if (wr_be[b]) mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
   end

   always_comb begin
      rd_word = mem_q[rd_addr];
      if (same_addr)
         for (int b = 0; b < NB; b++)
            if (wr_be[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
   end

`ifdef SRAM_PARITY_EN
   logic [NB-1:0] par_q [DEPTH];
   logic [NB-1:0] rd_par;

   always_ff @(posedge clk) begin
      if (init_we) begin
         par_q[init_addr] <= '0;
      end else if (wr_fire) begin
         for (int b = 0; b < NB; b++)
            if (wr_be[b]) par_q[wr_addr][b] <= ^wr_data[8*b +: 8];
      end
   end

   always_comb begin
      rd_par  = par_q[rd_addr];
      rd_perr = 1'b0;
      for (int b = 0; b < NB; b++) begin
         if (same_addr && wr_be[b]) rd_par[b] = ^wr_data[8*b +: 8];
         rd_perr = rd_perr | ((^rd_word[8*b +: 8]) ^ rd_par[b]);
      end
   end
`else
   assign rd_perr = 1'b0;
`endif

   logic                  s1_vld_q, s1_perr_q;
   logic [DATA_WIDTH-1:0] s1_dat_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q  <= 1'b0;
         s1_perr_q <= 1'b0;
         s1_dat_q  <= '0;
      end else begin
         s1_vld_q  <= rd_fire;
         s1_perr_q <= rd_fire & rd_perr;
         if (rd_fire) s1_dat_q <= rd_word;
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic                  s2_vld_q, s2_perr_q;
         logic [DATA_WIDTH-1:0] s2_dat_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s2_vld_q  <= 1'b0;
               s2_perr_q <= 1'b0;
               s2_dat_q  <= '0;
            end else begin
               s2_vld_q  <= s1_vld_q;
               s2_perr_q <= s1_perr_q;
               if (s1_vld_q) s2_dat_q <= s1_dat_q;
            end
         end

         assign rd_valid = s2_vld_q;
         assign rd_data  = s2_dat_q;
         assign par_err  = s2_perr_q;
      end else begin : g_lat1
         assign rd_valid = s1_vld_q;
         assign rd_data  = s1_dat_q;
         assign par_err  = s1_perr_q;
      end
   endgenerate

endmodule

// File: tb/tb_sram_dp_be.sv
// Directed bench for sram_dp_be: one instance at READ_LATENCY=1, one at 2, shared stimulus.
module tb_sram_dp_be;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic [1:0]  wr_be;
   logic        rd_en;
   logic [3:0]  rd_addr;

   logic [15:0] d1, d2;
   logic        v1, v2, b1, b2, p1, p2;

   int checks = 0;
   int passed = 0;
   int busy_cnt;
   logic saw_vld;

   always #5 clk = ~clk;

   sram_dp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .READ_LATENCY(1)) u1 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d1), .rd_valid(v1),
      .init_busy(b1), .par_err(p1)
   );

   sram_dp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .READ_LATENCY(2)) u2 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d2), .rd_valid(v2),
      .init_busy(b2), .par_err(p2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input logic en, input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
      wr_en   = en;
      wr_addr = a;
      wr_data = d;
      wr_be   = be;
   endtask

   task automatic set_rd(input logic en, input logic [3:0] a);
      rd_en   = en;
      rd_addr = a;
   endtask

   initial begin
      rst_n = 1'b0;
      set_wr(1'b0, 4'd0, 16'h0000, 2'b00);
      set_rd(1'b0, 4'd0);
      #1;
      chk("rst_rd_valid", {30'd0, v1, v2}, 32'd0);
      chk("rst_rd_data", {d1, d2}, 32'd0);
      chk("rst_init_busy", {30'd0, b1, b2}, 32'd3);
      chk("rst_par_err", {30'd0, p1, p2}, 32'd0);
      tick();
      tick();

      // Release reset with a read requested throughout INIT
      rst_n = 1'b1;
      set_rd(1'b1, 4'd0);
      busy_cnt = 0;
      saw_vld  = 1'b0;
      for (int i = 0; i < 40 && b1; i++) begin
         tick();
         busy_cnt++;
         saw_vld = saw_vld | v1 | v2;
      end
      chk("init_busy_cycles", busy_cnt, 32'd16);
      chk("no_valid_during_init", {31'd0, saw_vld}, 32'd0);
      chk("u2_init_done", {31'd0, b2}, 32'd0);

      for (int a = 0; a < 16; a++) begin
         set_rd(1'b1, 4'(a));
         tick();
         chk($sformatf("clear_rd%0d", a), {15'd0, v1, d1}, {15'd0, 1'b1, 16'h0000});
      end
      set_rd(1'b0, 4'd0);
      tick();
      chk("valid_drops", {31'd0, v1}, 32'd0);

      // Byte-enable merge
      set_wr(1'b1, 4'd3, 16'hABCD, 2'b11);
      tick();
      set_wr(1'b1, 4'd3, 16'h1200, 2'b10);
      tick();
      set_wr(1'b0, 4'd0, 16'h0000, 2'b00);
      set_rd(1'b1, 4'd3);
      tick();
      chk("be_merge_lat1", {15'd0, v1, d1}, {15'd0, 1'b1, 16'h12CD});
      set_rd(1'b0, 4'd0);
      tick();
      chk("hold_lat1", {15'd0, v1, d1}, {15'd0, 1'b0, 16'h12CD});
      chk("be_merge_lat2", {15'd0, v2, d2}, {15'd0, 1'b1, 16'h12CD});

      // Zero byte-enable leaves the word alone
      set_wr(1'b1, 4'd3, 16'hFFFF, 2'b00);
      tick();
      set_wr(1'b0, 4'd0, 16'h0000, 2'b00);
      set_rd(1'b1, 4'd3);
      tick();
      chk("be_zero", {15'd0, v1, d1}, {15'd0, 1'b1, 16'h12CD});

      // Write and read to different addresses in the same cycle
      set_wr(1'b1, 4'd4, 16'h5678, 2'b11);
      set_rd(1'b1, 4'd3);
      tick();
      chk("diff_addr_rd", d1, 32'h12CD);
      set_wr(1'b0, 4'd0, 16'h0000, 2'b00);
      set_rd(1'b1, 4'd4);
      tick();
      chk("diff_addr_wr", d1, 32'h5678);

      // Write-first bypass with partial byte enable
      set_rd(1'b0, 4'd0);
      set_wr(1'b1, 4'd5, 16'h00FF, 2'b11);
      tick();
      set_wr(1'b1, 4'd5, 16'h3344, 2'b01);
      set_rd(1'b1, 4'd5);
      tick();
      chk("write_first", {15'd0, v1, d1}, {15'd0, 1'b1, 16'h0044});
      chk("par_err_clean", {30'd0, p1, p2}, 32'd0);
      set_wr(1'b0, 4'd0, 16'h0000, 2'b00);
      tick();
      chk("write_first_lat2", {15'd0, v2, d2}, {15'd0, 1'b1, 16'h0044});
      chk("write_first_stored", d1, 32'h0044);

      // Burst of four reads; latency-2 instance lags by one more cycle
      set_rd(1'b0, 4'd0);
      for (int i = 0; i < 4; i++) begin
         set_wr(1'b1, 4'(i), 16'h1100 + 16'(i), 2'b11);
         tick();
      end
      set_wr(1'b0, 4'd0, 16'h0000, 2'b00);
      tick();
      tick();
      for (int k = 0; k < 6; k++) begin
         set_rd(k < 4, 4'(k));
         tick();
         chk($sformatf("burst_v1_%0d", k), {31'd0, v1}, {31'd0, k < 4});
         if (k < 4) chk($sformatf("burst_d1_%0d", k), d1, 32'h1100 + k);
         chk($sformatf("burst_v2_%0d", k), {31'd0, v2}, {31'd0, (k >= 1 && k <= 4)});
         if (k >= 1 && k <= 4) chk($sformatf("burst_d2_%0d", k), d2, 32'h1100 + k - 1);
      end

      // Reset with a read in flight in the latency-2 pipeline
      set_rd(1'b1, 4'd0);
      tick();
      rst_n = 1'b0;
      #1;
      chk("midread_rst_v2", {31'd0, v2}, 32'd0);
      chk("midread_rst_d", {d1, d2}, 32'd0);
      chk("midread_rst_busy", {30'd0, b1, b2}, 32'd3);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      rst_n = 1'b0;
      #1;
      chk("midinit_rst_busy", {31'd0, b1}, 32'd1);
      tick();
      rst_n = 1'b1;
      busy_cnt = 0;
      saw_vld  = 1'b0;
      for (int i = 0; i < 40 && b1; i++) begin
         tick();
         busy_cnt++;
         saw_vld = saw_vld | v1 | v2;
      end
      chk("reinit_busy_cycles", busy_cnt, 32'd16);
      chk("reinit_no_valid", {31'd0, saw_vld}, 32'd0);
      set_rd(1'b1, 4'd4);
      tick();
      chk("reinit_cleared", {15'd0, v1, d1}, {15'd0, 1'b1, 16'h0000});
      set_rd(1'b0, 4'd0);
      tick();

`ifdef SRAM_PARITY_EN
      set_wr(1'b1, 4'd2, 16'h00AA, 2'b11);
      tick();
      set_wr(1'b0, 4'd0, 16'h0000, 2'b00);
      u1.mem_q[2] = u1.mem_q[2] ^ 16'h0001;
      set_rd(1'b1, 4'd2);
      tick();
      chk("parity_err", {30'd0, v1, p1}, 32'd3);
      set_rd(1'b1, 4'd4);
      tick();
      chk("parity_clean", {30'd0, v1, p1}, 32'd2);
      set_rd(1'b0, 4'd0);
      tick();
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
